// File: rtl/bmp280_seq_ctrl_pkg.sv
// rtl/bmp280_seq_ctrl_pkg.sv - BMP280 register map, burst sizes and sequencer state encoding
//
// Shared constants for the BMP280 sequencer: sensor register addresses,
// expected chip ID, burst lengths and the sequencer state type.
package bmp280_pkg;

    localparam logic [7:0] REG_ID        = 8'hD0;
    localparam logic [7:0] REG_CTRL_MEAS = 8'hF4;
    localparam logic [7:0] REG_CAL0      = 8'h88;
    localparam logic [7:0] REG_RAW0      = 8'hF7;

    localparam logic [7:0] CHIP_ID = 8'h58;

    localparam int CAL_BYTES = 24;
    localparam int RAW_BYTES = 6;

    typedef enum logic [2:0] {
        ST_ID   = 3'd0,
        ST_CFG  = 3'd1,
        ST_CAL  = 3'd2,
        ST_WAIT = 3'd3,
        ST_RAW  = 3'd4,
        ST_ERR  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/bmp280_seq_ctrl_if.sv
// rtl/bmp280_seq_ctrl_if.sv - req/ack handshake between sequencer and byte-level register engine
//
// Signals:
//   bus_req   sequencer -> engine  request, held until bus_ack
//   bus_we    sequencer -> engine  1 = write, 0 = read
//   bus_addr  sequencer -> engine  sensor register address
//   bus_wdata sequencer -> engine  write data
//   bus_ack   engine -> sequencer  one-cycle completion strobe
//   bus_rdata engine -> sequencer  read byte, valid with bus_ack
//   bus_err   engine -> sequencer  access failed, valid with bus_ack
interface bmp280_seq_ctrl_if;

    logic       bus_req;
    logic       bus_we;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic       bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata, bus_err
    );

endinterface

// File: rtl/bmp280_seq_ctrl.sv
// rtl/bmp280_seq_ctrl.sv - BMP280 chip-ID check, configuration, calibration and raw-data polling sequencer
//
// Ports:
//   clk, reset   system clock, asynchronous active-high reset
//   restart      one-cycle pulse, re-runs the sequence from the chip-ID check
//   bus          master side of the register-access handshake
//   cal_bus      12 little-endian calibration words, word k at [16k+15:16k]
//   cal_valid    sticky, all calibration bytes captured
//   raw_temp     latest uncompensated temperature
//   raw_press    latest uncompensated pressure
//   data_valid   one-cycle pulse when raw_temp/raw_press update
//   busy         mirrors bus_req
//   err          sticky error flag
module bmp280_seq_ctrl
    import bmp280_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 50_000_000,
    parameter logic [7:0]  CTRL_MEAS   = 8'h27
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    restart,
    bmp280_seq_ctrl_if.master       bus,
    output logic [191:0]            cal_bus,
    output logic                    cal_valid,
    output logic [19:0]             raw_temp,
    output logic [19:0]             raw_press,
    output logic                    data_valid,
    output logic                    busy,
    output logic                    err
);

    // WAIT is left two cycles early: one cycle to enter RAW, one idle cycle
    // before the request rises, giving POLL_CYCLES from data_valid to bus_req.
    localparam logic [31:0] TIMER_LAST = 32'(POLL_CYCLES - 2);

    seq_state_t  state, state_n;
    logic        req_q, req_n;
    logic        we_q, we_n;
    logic [7:0]  addr_q, addr_n;
    logic [7:0]  wdata_q, wdata_n;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] timer, timer_n;
    logic        pend, pend_n;      // restart seen while a request is outstanding
    logic [7:0]  raw_sh [0:4];      // first five raw bytes; the sixth comes straight from the bus

    logic ack;
    logic cal_we, cal_done, sh_we, raw_upd, err_set, flag_clr;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign busy          = req_q;

    // An ack only counts against our own outstanding request.
    assign ack = req_q && bus.bus_ack;

    always_comb begin
        state_n  = state;
        req_n    = req_q;
        we_n     = we_q;
        addr_n   = addr_q;
        wdata_n  = wdata_q;
        cnt_n    = cnt;
        timer_n  = timer;
        pend_n   = pend;
        cal_we   = 1'b0;
        cal_done = 1'b0;
        sh_we    = 1'b0;
        raw_upd  = 1'b0;
        err_set  = 1'b0;
        flag_clr = restart;

        if ((restart || pend) && (!req_q || ack)) begin
            // Restart takes effect once the bus is quiet; any ack here is discarded.
            state_n = ST_ID;
            req_n   = 1'b0;
            cnt_n   = 5'd0;
            timer_n = 32'd0;
            pend_n  = 1'b0;
        end else if (restart) begin
            pend_n = 1'b1;
        end else if (pend) begin
            // hold the request until the engine acks it
        end else if (ack) begin
            req_n = 1'b0;
            if (bus.bus_err) begin
                state_n = ST_ERR;
                err_set = 1'b1;
            end else begin
                unique case (state)
                    ST_ID: begin
                        if (bus.bus_rdata == CHIP_ID) begin
                            state_n = ST_CFG;
                        end else begin
                            state_n = ST_ERR;
                            err_set = 1'b1;
                        end
                    end
                    ST_CFG: begin
                        state_n = ST_CAL;
                        cnt_n   = 5'd0;
                    end
                    ST_CAL: begin
                        cal_we = 1'b1;
                        if (cnt == 5'(CAL_BYTES - 1)) begin
                            cal_done = 1'b1;
                            state_n  = ST_RAW;
                            cnt_n    = 5'd0;
                        end else begin
                            cnt_n = cnt + 5'd1;
                        end
                    end
                    ST_RAW: begin
                        if (cnt == 5'(RAW_BYTES - 1)) begin
                            raw_upd = 1'b1;
                            state_n = ST_WAIT;
                            timer_n = 32'd0;
                            cnt_n   = 5'd0;
                        end else begin
                            sh_we = 1'b1;
                            cnt_n = cnt + 5'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end else if (!req_q) begin
            unique case (state)
                ST_ID: begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = REG_ID;
                end
                ST_CFG: begin
                    req_n   = 1'b1;
                    we_n    = 1'b1;
                    addr_n  = REG_CTRL_MEAS;
                    wdata_n = CTRL_MEAS;
                end
                ST_CAL: begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = REG_CAL0 + {3'b000, cnt};
                end
                ST_RAW: begin
                    req_n  = 1'b1;
                    we_n   = 1'b0;
                    addr_n = REG_RAW0 + {3'b000, cnt};
                end
                ST_WAIT: begin
                    if (timer == TIMER_LAST) begin
                        state_n = ST_RAW;
                        cnt_n   = 5'd0;
                    end else begin
                        timer_n = timer + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_ID;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            cnt     <= 5'd0;
            timer   <= 32'd0;
            pend    <= 1'b0;
        end else begin
            state   <= state_n;
            req_q   <= req_n;
            we_q    <= we_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            cnt     <= cnt_n;
            timer   <= timer_n;
            pend    <= pend_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cal_bus    <= '0;
            cal_valid  <= 1'b0;
            raw_temp   <= '0;
            raw_press  <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
            for (int i = 0; i < 5; i++) raw_sh[i] <= 8'd0;
        end else begin
            data_valid <= raw_upd;
            if (cal_we) cal_bus[{cnt, 3'b000} +: 8] <= bus.bus_rdata;
            if (sh_we)  raw_sh[cnt[2:0]] <= bus.bus_rdata;
            if (raw_upd) begin
                raw_press <= {raw_sh[0], raw_sh[1], raw_sh[2][7:4]};
                raw_temp  <= {raw_sh[3], raw_sh[4], bus.bus_rdata[7:4]};
            end
            if (flag_clr)      cal_valid <= 1'b0;
            else if (cal_done) cal_valid <= 1'b1;
            if (flag_clr)      err <= 1'b0;
            else if (err_set)  err <= 1'b1;
        end
    end

endmodule
